// File: rtl/legv8_pkg.sv
// legv8_pkg -- constants shared by the LEGv8 decode stage.
//   N_DEFAULT     : default register/data width
//   XZR           : index of the zero register
//   OP_*          : opcode fields used by the immediate decoder
//   imm_kind_e    : which immediate field an instruction carries
package legv8_pkg;

  localparam int N_DEFAULT = 64;

  localparam logic [4:0] XZR = 5'd31;

  // Full 11-bit opcodes for the D-format loads/stores.
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  // CB-format uses the top 8 bits, B-format the top 6 bits.
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_D    = 2'd1,  // 9-bit address offset (LDUR/STUR)
    IMM_CB   = 2'd2,  // 19-bit branch offset (CBZ)
    IMM_B    = 2'd3   // 26-bit branch offset (B)
  } imm_kind_e;

  // Classify an instruction word; the order of the tests is the priority.
  function automatic imm_kind_e imm_kind(input logic [31:0] instr);
    imm_kind_e kind;
    kind = IMM_NONE;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      kind = IMM_D;
    end else if (instr[31:24] == OP_CBZ) begin
      kind = IMM_CB;
    end else if (instr[31:26] == OP_B) begin
      kind = IMM_B;
    end
    return kind;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if -- bundles the decode stage's instruction, write-back and
// operand signals.
//   master : upstream/downstream datapath side (drives instruction and
//            write-back, receives operands and immediate)
//   slave  : the decode stage itself
interface decode_if #(
  parameter int N = 64
);
  logic [31:0]  instr_D;
  logic         reg2loc_D;
  logic         regWrite_D;
  logic [4:0]   wa3_D;
  logic [N-1:0] writeData3_D;
  logic [N-1:0] readData1_D;
  logic [N-1:0] readData2_D;
  logic [N-1:0] signImm_D;

  modport master (
    output instr_D, reg2loc_D, regWrite_D, wa3_D, writeData3_D,
    input  readData1_D, readData2_D, signImm_D
  );

  modport slave (
    input  instr_D, reg2loc_D, regWrite_D, wa3_D, writeData3_D,
    output readData1_D, readData2_D, signImm_D
  );
endinterface

// File: rtl/decode_regfile.sv
// regfile -- LEGv8 architectural register file, two combinational read
// ports and one write port.
//   clk, reset   : clock; asynchronous active-low reset (Xi <- i)
//   we, wa, wd   : write enable, address, data (sampled on rising edge)
//   ra1, ra2     : read addresses
//   rd1, rd2     : read data (combinational, X31 always 0)
module regfile
  import legv8_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [4:0]   wa,
  input  logic [N-1:0] wd,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2
);

  // Only X0..X(NREGS-2) have storage; the top index is the zero register.
  logic [N-1:0] regs_reg [NREGS-1];
  logic [N-1:0] read_view [NREGS];
  logic         wr_en;

  // Writes to XZR are dropped here so no storage slot is ever selected.
  assign wr_en = we && (wa != XZR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs_reg[i] <= N'(i);
      end
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (wr_en && wa == 5'(i)) begin
          regs_reg[i] <= wd;
        end
      end
    end
  end

  // Flat view of all NREGS architectural registers with XZR hard-wired to 0.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_view
      if (gi == NREGS - 1) begin : g_zero
        assign read_view[gi] = '0;
      end else begin : g_reg
        assign read_view[gi] = regs_reg[gi];
      end
    end
  endgenerate

  // Reads see the pre-edge contents: no bypass from the write port.
  assign rd1 = read_view[ra1];
  assign rd2 = read_view[ra2];

endmodule

// File: rtl/decode.sv
// decode -- decode stage of the single-cycle LEGv8 datapath.
//   clk    : clock (register file writes on rising edge)
//   reset  : asynchronous active-low reset of the register file
//   dif    : decode_if.slave
//            instr_D, reg2loc_D            -> operand/immediate selection
//            regWrite_D, wa3_D, writeData3_D -> register write-back
//            readData1_D (Rn), readData2_D (Rm or Rt), signImm_D
// All outputs are combinational from the instruction and register state.
module decode
  import legv8_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int NREGS = 32
) (
  input  logic clk,
  input  logic reset,
  decode_if.slave dif
);

  logic [4:0]   ra1;
  logic [4:0]   ra2;
  logic [N-1:0] imm_next;
  imm_kind_e    kind;

  // Rn is always port 1; port 2 is Rm for R-format, Rt for stores/CBZ.
  assign ra1 = dif.instr_D[9:5];
  assign ra2 = dif.reg2loc_D ? dif.instr_D[4:0] : dif.instr_D[20:16];

  regfile #(
    .N     (N),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (dif.regWrite_D),
    .wa    (dif.wa3_D),
    .wd    (dif.writeData3_D),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (dif.readData1_D),
    .rd2   (dif.readData2_D)
  );

  // Immediate is sign-extended but left unshifted; branch scaling by 4
  // happens in execute.
  always_comb begin
    imm_next = '0;
    kind     = imm_kind(dif.instr_D);
    case (kind)
      IMM_D:   imm_next = {{(N-9){dif.instr_D[20]}},  dif.instr_D[20:12]};
      IMM_CB:  imm_next = {{(N-19){dif.instr_D[23]}}, dif.instr_D[23:5]};
      IMM_B:   imm_next = {{(N-26){dif.instr_D[25]}}, dif.instr_D[25:0]};
      default: imm_next = '0;
    endcase
  end

  assign dif.signImm_D = imm_next;

endmodule

// File: tb/tb_decode.sv
// tb_decode -- scoreboard bench for decode: each stimulus step pushes the
// reference-model expectation, a monitor pops and compares on the falling
// edge, before the next write edge.
module tb_decode;

  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;

  decode_if #(.N(N)) dif ();

  decode #(
    .N     (N),
    .NREGS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [32];
  int          errors = 0;
  int          checks = 0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    return model[idx];
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint v;
    v = 0;
    if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
      v = longint'(w[20:12]);
      if (v >= 256) v = v - 512;
    end else if (w[31:24] == 8'hB4) begin
      v = longint'(w[23:5]);
      if (v >= (longint'(1) << 18)) v = v - (longint'(1) << 19);
    end else if (w[31:26] == 6'b000101) begin
      v = longint'(w[25:0]);
      if (v >= (longint'(1) << 25)) v = v - (longint'(1) << 26);
    end
    return 64'(v);
  endfunction

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] f_ldur(input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
    return {11'b111_1100_0010, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] f_stur(input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
    return {11'b111_1100_0000, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] f_cbz(input logic [18:0] imm, input logic [4:0] rt);
    return {8'b1011_0100, imm, rt};
  endfunction
  function automatic logic [31:0] f_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] f_add(input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {11'b10001011000, rm, 6'd0, rn, rd};
  endfunction

  // ---------------- stimulus step ----------------
  // Called just after a rising edge. Drives inputs, queues the expectation
  // from the pre-edge model, then advances past the next rising edge.
  task automatic step(input logic rst_v, input logic [31:0] instr, input logic r2l,
                      input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input string tag);
    exp_t e;
    logic [4:0] ra2;
    reset            = rst_v;
    dif.instr_D      = instr;
    dif.reg2loc_D    = r2l;
    dif.regWrite_D   = we;
    dif.wa3_D        = wa;
    dif.writeData3_D = wd;
    #1;
    if (!rst_v) begin
      for (int i = 0; i < 32; i++) model[i] = 64'(i);
    end
    ra2   = r2l ? instr[4:0] : instr[20:16];
    e.rd1 = ref_read(instr[9:5]);
    e.rd2 = ref_read(ra2);
    e.imm = ref_imm(instr);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_v && we && wa != 5'd31) model[wa] = wd;
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string tag, input string what, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.tag, "rd1", dif.readData1_D, e.rd1);
        cmp(e.tag, "rd2", dif.readData2_D, e.rd2);
        cmp(e.tag, "imm", dif.signImm_D,   e.imm);
        $display("check %s rd1=%h rd2=%h imm=%h", e.tag, dif.readData1_D, dif.readData2_D, dif.signImm_D);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    reset            = 1'b0;
    dif.instr_D      = 32'd0;
    dif.reg2loc_D    = 1'b0;
    dif.regWrite_D   = 1'b0;
    dif.wa3_D        = 5'd0;
    dif.writeData3_D = 64'd0;
    for (int i = 0; i < 32; i++) model[i] = 64'(i);
    @(posedge clk);
    #1;

    // Reset state and writes ignored under reset.
    step(1'b0, 32'hF84083E1, 1'b1, 1'b0, 5'd0, 64'd0, "rst_ldur");
    step(1'b0, f_ldur(9'd0, 5'd3, 5'd4), 1'b1, 1'b1, 5'd3, 64'hFFFF, "rst_wr_ignored");
    step(1'b0, f_ldur(9'd0, 5'd3, 5'd30), 1'b1, 1'b0, 5'd0, 64'd0, "rst_x3_held");

    // First write accepted on first edge with reset high; no bypass.
    step(1'b1, f_stur(9'd4, 5'd5, 5'd3), 1'b1, 1'b1, 5'd5, 64'h16e10b5ef5732a68, "wr_x5_old");
    step(1'b1, f_stur(9'd4, 5'd5, 5'd5), 1'b1, 1'b0, 5'd0, 64'd0, "wr_x5_new");

    // XZR writes discarded.
    step(1'b1, f_ldur(9'd0, 5'd31, 5'd30), 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, "wr_x31");
    step(1'b1, f_ldur(9'd0, 5'd31, 5'd30), 1'b1, 1'b0, 5'd0, 64'd0, "x31_after");

    // Immediate boundaries.
    step(1'b1, f_cbz(19'h7FFFF, 5'd2), 1'b1, 1'b0, 5'd0, 64'd0, "cbz_neg");
    step(1'b1, f_b(26'h0000010), 1'b0, 1'b0, 5'd0, 64'd0, "b_pos");
    step(1'b1, f_b(26'h2000000), 1'b0, 1'b0, 5'd0, 64'd0, "b_min");
    step(1'b1, f_stur(9'h100, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 64'd0, "stur_neg");
    step(1'b1, f_ldur(9'h0FF, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 64'd0, "ldur_max");
    step(1'b1, f_add(5'd5, 5'd2, 5'd7), 1'b0, 1'b1, 5'd2, 64'hAAAA, "add_zero");

    // Asynchronous reset between edges restores index value at once.
    step(1'b1, f_add(5'd5, 5'd2, 5'd7), 1'b0, 1'b0, 5'd0, 64'd0, "x2_written");
    step(1'b0, f_add(5'd5, 5'd2, 5'd7), 1'b0, 1'b1, 5'd2, 64'h1234, "x2_async_rst");
    step(1'b1, f_add(5'd5, 5'd2, 5'd7), 1'b0, 1'b0, 5'd0, 64'd0, "x2_released");

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       w = f_ldur(9'($urandom), 5'($urandom), 5'($urandom));
        1:       w = f_stur(9'($urandom), 5'($urandom), 5'($urandom));
        2:       w = f_cbz(19'($urandom), 5'($urandom));
        3:       w = f_b(26'($urandom));
        4:       w = f_add(5'($urandom), 5'($urandom), 5'($urandom));
        default: w = $urandom;
      endcase
      step(($urandom_range(0, 24) != 0), w, 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 31)), {$urandom, $urandom}, "rand");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
